// File: rtl/prog_truth_table_gate.sv
// Runtime-programmable N-input truth-table gate. The table is shifted in serially and committed
// atomically; inputs must stay stable for SETTLE edges before the registered output is re-evaluated.
module prog_truth_table_gate #(
  parameter int                   N_IN    = 3,
  parameter logic [(1<<N_IN)-1:0] INIT_TT = 'h27,
  parameter int                   SETTLE  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  input  logic            cfg_en,
  input  logic            cfg_bit,
  output logic            cfg_done,
  output logic            out,
  output logic            out_valid,
  output logic            changed
);
  localparam int         TTW         = 1 << N_IN;
  localparam logic [7:0] SETTLE_CNT  = 8'(SETTLE);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  typedef enum logic {S_UNSETTLED, S_SETTLED} state_t;

  logic [TTW-1:0]  r_tt;
  logic [TTW-2:0]  r_shadow;
  logic [N_IN-1:0] r_bitcnt;
  logic            r_done;

  state_t          r_state;
  logic [N_IN-1:0] r_in_q;
  logic [7:0]      r_cnt;
  logic            r_out;
  logic            r_valid;
  logic            r_changed;

  logic [TTW-1:0]  w_shift;
  logic            w_commit;
  logic [N_IN-1:0] w_idx;
  logic            w_eval;

  state_t          w_state_nxt;
  logic [N_IN-1:0] w_in_q_nxt;
  logic [7:0]      w_cnt_nxt;
  logic            w_out_nxt;
  logic            w_valid_nxt;
  logic            w_changed_nxt;

  assign w_shift  = {r_shadow, cfg_bit};
  assign w_commit = cfg_en && (r_bitcnt == '1);
  // TTW-1-i equals the bitwise inverse of i, so index 0 selects the table MSB.
  assign w_idx    = ~r_in_q;
  assign w_eval   = r_tt[w_idx];

  // Serial table loader: shadow collects bits, the last bit commits the whole table at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tt     <= INIT_TT;
      r_shadow <= '0;
      r_bitcnt <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (cfg_en) begin
        r_shadow <= w_shift[TTW-2:0];
        r_bitcnt <= w_commit ? '0 : r_bitcnt + N_IN'(1);
        if (w_commit) begin
          r_tt <= w_shift;
        end
      end else begin
        r_bitcnt <= '0;
      end
    end
  end

  // Settle filter: an input change or a table commit restarts the window; out holds until re-evaluated.
  always_comb begin
    w_state_nxt   = r_state;
    w_in_q_nxt    = r_in_q;
    w_cnt_nxt     = r_cnt;
    w_out_nxt     = r_out;
    w_valid_nxt   = r_valid;
    w_changed_nxt = 1'b0;
    if ((in != r_in_q) || w_commit) begin
      w_in_q_nxt  = in;
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_state_nxt = S_UNSETTLED;
    end else begin
      case (r_state)
        S_UNSETTLED: begin
          if (r_cnt == SETTLE_LAST) begin
            w_cnt_nxt     = SETTLE_CNT;
            w_out_nxt     = w_eval;
            w_valid_nxt   = 1'b1;
            w_changed_nxt = (w_eval != r_out);
            w_state_nxt   = S_SETTLED;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        S_SETTLED: begin
          w_cnt_nxt = r_cnt;
        end
        default: begin
          w_state_nxt = S_UNSETTLED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_UNSETTLED;
      r_in_q    <= '0;
      r_cnt     <= '0;
      r_out     <= 1'b0;
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_q    <= w_in_q_nxt;
      r_cnt     <= w_cnt_nxt;
      r_out     <= w_out_nxt;
      r_valid   <= w_valid_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  assign cfg_done  = r_done;
  assign out       = r_out;
  assign out_valid = r_valid;
  assign changed   = r_changed;

endmodule
